key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
Push-button conditioning stage that sits directly upstream of the single-pulse/edge stages. It takes a raw, asynchronous, bouncing key input and synchronises it to clk. It filters contact bounce with a counter-based FSM and outputs a clean debounced level plus one-cycle press and release strobes. Downstream counters and mode selectors consume either the level or the strobes directly.

Parameters:
DEBOUNCE_CYCLES, 240000, consecutive stable cycles required to accept a level change (20 ms at 12 MHz); legal range >= 1.
KEY_ACTIVE_LOW, 1, 1 = key_in reads 0 when pressed; 0 = key_in reads 1 when pressed.
LONG_CYCLES, 12000000, hold time for the long-press strobe (1 s at 12 MHz); used only with the optional feature; legal range >= 1.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
key_in  input  1  raw asynchronous button pin
key_level  output  1  debounced state; 1 = pressed
press_pulse  output  1  one-cycle strobe when a press is accepted
release_pulse  output  1  one-cycle strobe when a release is accepted
long_pulse  output  1  one-cycle long-press strobe; constant 0 without the optional feature

Behaviour:
- Reset:
  - rst_n is synchronous, active-low; clock is clk.
  - While rst_n=0: state=RELEASED, counters=0, key_level=0, press_pulse=0, release_pulse=0, long_pulse=0.
  - Both synchroniser flops reset to the released pin level: 1 if KEY_ACTIVE_LOW, else 0.
- Input path:
  - key_in passes through a 2-flop synchroniser.
  - The result is polarity-normalised to k_s (1 = pressed).
  - Only k_s is used after this point.
- Counter: cnt is $clog2(DEBOUNCE_CYCLES+1) bits wide and saturates (never wraps).
- FSM states and transitions:
  - RELEASED: if k_s=1, go to PRESS_CHK and set cnt=0.
  - PRESS_CHK:
    - if k_s=0, go to RELEASED (bounce rejected, no strobe);
    - else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED;
    - else cnt++.
  - PRESSED: if k_s=0, go to RELEASE_CHK and set cnt=0.
  - RELEASE_CHK:
    - if k_s=1, go to PRESSED (glitch rejected);
    - else if cnt==DEBOUNCE_CYCLES-1, go to RELEASED;
    - else cnt++.
- Outputs:
  - All outputs are registered.
  - key_level=1 exactly while state is PRESSED or RELEASE_CHK.
  - press_pulse=1 for exactly one cycle after the edge that performs PRESS_CHK->PRESSED.
  - release_pulse=1 for exactly one cycle after the edge that performs RELEASE_CHK->RELEASED.
- Latency:
  - Number the first rising edge that samples key_in at a new, stable level as edge 1.
  - The strobe and the key_level change appear after edge DEBOUNCE_CYCLES+3.
- Boundary conditions:
  - press_pulse and release_pulse are never high in the same cycle.
  - Two strobes are separated by at least DEBOUNCE_CYCLES+1 cycles.
  - Any bounce during a CHK state restarts the count from 0 on the next entry into that CHK state.
- Reset mid-operation:
  - Any state returns to RELEASED with no strobe.
  - If the key is held through reset release, it is treated as a new press: press_pulse follows after the full latency.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Defined:
  - A hold counter of $clog2(LONG_CYCLES+1) bits clears on entry to PRESSED.
  - It counts every cycle spent in PRESSED or RELEASE_CHK and saturates.
  - long_pulse is high for one cycle LONG_CYCLES edges after the press_pulse edge.
  - It fires at most once per press; a new press is required to fire again.
- Not defined: no hold counter is built and long_pulse is tied to 0. The port list is unchanged.

Decomposition:
- Shared package key_pkg holds:
  - 2-bit state encodings: RELEASED=0, PRESS_CHK=1, PRESSED=2, RELEASE_CHK=3;
  - default cycle constants for the 12 MHz board clock: 20 ms and 1 s.
- Sub-module key_sync: 2-flop synchroniser with parameter RESET_VAL, synchronous active-low reset. It is reused by other input-conditioning blocks.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, KEY_ACTIVE_LOW=1.
1. Clean press: key_in 1->0 held 30 cycles -> press_pulse high for 1 cycle after edge 7; key_level=1 from that cycle; release_pulse stays 0.
2. Bouncy press: key_in low 2, high 1, low 1, high 1, then low steady -> no strobe during the bounce; exactly one press_pulse, 7 edges after the final fall.
3. Release with glitch: from PRESSED, key_in high 3 cycles then low -> no release_pulse, key_level stays 1. Then key_in high steady -> release_pulse after edge 7 and key_level=0.
4. Reset mid-check: assert rst_n=0 during PRESS_CHK for 2 cycles with key held -> all outputs 0 during reset. After rst_n=1 with key still held -> press_pulse after edge 7 following release.
5. Long press with KEY_LONG_PRESS_EN: hold 50 cycles -> long_pulse once, 20 edges after the press_pulse edge, and not again. Same stimulus without the macro -> long_pulse=0 throughout.
6. Polarity: KEY_ACTIVE_LOW=0, key_in 0->1 held -> press_pulse after edge 7. Idle key_in=0 after reset -> no spurious strobe.

Source files
------------

// File: rtl/key_pkg.sv
// Shared state encodings and 12 MHz board-clock defaults for the push-button
// conditioning blocks.
package key_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } key_state_e;

    localparam int unsigned CLK_HZ               = 12_000_000;
    localparam int unsigned DEBOUNCE_20MS_CYCLES = CLK_HZ / 50;
    localparam int unsigned LONG_1S_CYCLES       = CLK_HZ;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for asynchronous input pins; both flops reset to
// RESET_VAL so the idle pin level produces no edge after reset.
module key_sync
    import key_pkg::*;
#(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronise, filter bounce with a counter FSM, emit a
// clean level plus press/release strobes. KEY_LONG_PRESS_EN adds a long-press strobe.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS_CYCLES,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned LONG_CYCLES     = LONG_1S_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES == 0 || LONG_CYCLES == 0) begin : g_bad_param
        $error("key_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
    end

    logic       pin_sync;
    logic       k_s;
    key_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;

    key_sync #(
        .RESET_VAL (KEY_ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (key_in),
        .q_o   (pin_sync)
    );

    // Normalise so that 1 always means pressed.
    assign k_s = pin_sync ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (k_s) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!k_s) begin
                    state_d = ST_RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                if (!k_s) begin
                    state_d = ST_RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_CHK: begin
                if (k_s) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RELEASED;
                    release_d = 1'b1;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_CHK);
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    // Saturation makes the fire value reachable only once per accepted press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (press_d) begin
            hold_d = '0;
        end else if (level_q) begin
            if (hold_q != HOLD_SAT) begin
                hold_d = hold_q + HOLD_W'(1);
            end
            long_d = (hold_q == HOLD_FIRE);
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: an active-low and an active-high instance checked every
// cycle against a run-length model, plus directed literal latency checks.
module tb_key_debounce;

    localparam int unsigned DC = 4;
    localparam int unsigned LC = 20;
`ifdef KEY_LONG_PRESS_EN
    localparam bit EXP_LONG = 1'b1;
`else
    localparam bit EXP_LONG = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key   = 2'b01;
    logic [1:0] act_low = 2'b01;
    logic [1:0] lvl_o, prs_o, rel_o, lng_o;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    key_debounce #(
        .DEBOUNCE_CYCLES (DC),
        .KEY_ACTIVE_LOW  (1'b1),
        .LONG_CYCLES     (LC)
    ) u_dut_al (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key[0]),
        .key_level     (lvl_o[0]),
        .press_pulse   (prs_o[0]),
        .release_pulse (rel_o[0]),
        .long_pulse    (lng_o[0])
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DC),
        .KEY_ACTIVE_LOW  (1'b0),
        .LONG_CYCLES     (LC)
    ) u_dut_ah (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key[1]),
        .key_level     (lvl_o[1]),
        .press_pulse   (prs_o[1]),
        .release_pulse (rel_o[1]),
        .long_pulse    (lng_o[1])
    );

    always #5 clk = ~clk;

    // Model: a level flips once DC+1 consecutive synchronised samples disagree with it.
    bit sy1[2], sy2[2], m_lvl[2], m_prs[2], m_rel[2], m_lng[2];
    int run[2], since[2];

    always @(posedge clk) begin
        started = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bit obs;
            m_prs[i] = 1'b0;
            m_rel[i] = 1'b0;
            m_lng[i] = 1'b0;
            if (!rst_n) begin
                sy1[i] = 1'b0; sy2[i] = 1'b0; m_lvl[i] = 1'b0;
                run[i] = 0; since[i] = 0;
            end else begin
                obs    = sy2[i];
                sy2[i] = sy1[i];
                sy1[i] = key[i] ^ act_low[i];
                run[i] = (obs != m_lvl[i]) ? run[i] + 1 : 0;
`ifdef KEY_LONG_PRESS_EN
                if (m_lvl[i]) begin
                    since[i] = since[i] + 1;
                    m_lng[i] = (since[i] == int'(LC));
                end
`endif
                if (run[i] == int'(DC) + 1) begin
                    m_lvl[i] = !m_lvl[i];
                    run[i]   = 0;
                    if (m_lvl[i]) begin
                        m_prs[i] = 1'b1;
                        since[i] = 0;
                    end else begin
                        m_rel[i] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_level%0d", i), lvl_o[i], m_lvl[i]);
                chk($sformatf("model_press%0d", i), prs_o[i], m_prs[i]);
                chk($sformatf("model_release%0d", i), rel_o[i], m_rel[i]);
                chk($sformatf("model_long%0d", i), lng_o[i], m_lng[i]);
                chk($sformatf("strobe_excl%0d", i), prs_o[i] & rel_o[i], 1'b0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 2'b01;
        step(3);
        chk("rst_level", lvl_o[0], 1'b0);
        chk("rst_press", prs_o[0], 1'b0);
        chk("rst_long",  lng_o[0], 1'b0);
        rst_n = 1'b1;
        step(10);
        chk("idle_ah_press", prs_o[1], 1'b0);
        chk("idle_ah_level", lvl_o[1], 1'b0);

        // Clean press held 50 cycles, with long-press timing.
        key[0] = 1'b0;
        step(6);
        chk("t1_press_e6", prs_o[0], 1'b0);
        chk("t1_level_e6", lvl_o[0], 1'b0);
        step(1);
        chk("t1_press_e7", prs_o[0], 1'b1);
        chk("t1_level_e7", lvl_o[0], 1'b1);
        chk("t1_rel_e7",   rel_o[0], 1'b0);
        step(1);
        chk("t1_press_e8", prs_o[0], 1'b0);
        chk("t1_level_e8", lvl_o[0], 1'b1);
        step(18);
        chk("t5_long_e26", lng_o[0], 1'b0);
        step(1);
        chk("t5_long_e27", lng_o[0], EXP_LONG);
        step(1);
        chk("t5_long_e28", lng_o[0], 1'b0);
        step(22);

        // Release glitch rejected, then a real release.
        key[0] = 1'b1;
        step(3);
        key[0] = 1'b0;
        step(10);
        chk("t3_glitch_level", lvl_o[0], 1'b1);
        key[0] = 1'b1;
        step(6);
        chk("t3_rel_e6",   rel_o[0], 1'b0);
        chk("t3_level_e6", lvl_o[0], 1'b1);
        step(1);
        chk("t3_rel_e7",   rel_o[0], 1'b1);
        chk("t3_level_e7", lvl_o[0], 1'b0);
        step(1);
        chk("t3_rel_e8",   rel_o[0], 1'b0);
        step(10);

        // Bouncy press.
        key[0] = 1'b0; step(2);
        key[0] = 1'b1; step(1);
        key[0] = 1'b0; step(1);
        key[0] = 1'b1; step(1);
        key[0] = 1'b0;
        step(6);
        chk("t2_press_e6", prs_o[0], 1'b0);
        step(1);
        chk("t2_press_e7", prs_o[0], 1'b1);
        step(10);
        key[0] = 1'b1;
        step(15);

        // Reset during PRESS_CHK with the key held.
        key[0] = 1'b0;
        step(4);
        rst_n = 1'b0;
        step(1);
        chk("t4_rst1_level", lvl_o[0], 1'b0);
        chk("t4_rst1_press", prs_o[0], 1'b0);
        step(1);
        chk("t4_rst2_level", lvl_o[0], 1'b0);
        chk("t4_rst2_press", prs_o[0], 1'b0);
        rst_n = 1'b1;
        step(6);
        chk("t4_press_e6", prs_o[0], 1'b0);
        step(1);
        chk("t4_press_e7", prs_o[0], 1'b1);
        chk("t4_level_e7", lvl_o[0], 1'b1);
        step(10);
        key[0] = 1'b1;
        step(15);

        // Active-high instance press and release.
        key[1] = 1'b1;
        step(6);
        chk("t6_press_e6", prs_o[1], 1'b0);
        step(1);
        chk("t6_press_e7", prs_o[1], 1'b1);
        chk("t6_level_e7", lvl_o[1], 1'b1);
        step(1);
        chk("t6_press_e8", prs_o[1], 1'b0);
        step(10);
        key[1] = 1'b0;
        step(15);
        chk("t6_level_end", lvl_o[1], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
